// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the memory arbiter slice.
//   arb_state_e : arbiter FSM states (IDLE / ISSUE / RESP)
//   owner_e     : which port owns the access in flight (CPU / LDR)
//   rr_pick     : two-way round-robin winner selection
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_e;

  // After reset the loader counts as last granted, so the CPU wins the first tie.
  localparam owner_e RST_LAST_GNT = OWN_LDR;

  // Winner of a two-way request: on a tie the port that was NOT granted last
  // wins; a single requester always wins. Result is only meaningful when at
  // least one request is present.
  function automatic owner_e rr_pick(input logic   req_cpu,
                                     input logic   req_ldr,
                                     input owner_e last_gnt);
    owner_e win;
    if (req_cpu && req_ldr) begin
      win = (last_gnt == OWN_CPU) ? OWN_LDR : OWN_CPU;
    end else if (req_ldr) begin
      win = OWN_LDR;
    end else begin
      win = OWN_CPU;
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter: combinational pick plus a registered
// last-granted flag.
//   clk, rst_n  : clock, synchronous active-low reset
//   i_en        : grant allowed this cycle (arbiter idle and out of reset)
//   i_req_cpu   : CPU eligible request
//   i_req_ldr   : loader eligible request
//   o_gnt_cpu   : CPU granted this cycle
//   o_gnt_ldr   : loader granted this cycle
// -----------------------------------------------------------------------------
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_req_cpu,
  input  logic i_req_ldr,
  output logic o_gnt_cpu,
  output logic o_gnt_ldr
);

  owner_e r_last;
  owner_e w_pick;
  logic   w_any;

  // Combinational winner selection, gated by the enable
  always_comb begin
    w_any     = i_en & (i_req_cpu | i_req_ldr);
    w_pick    = rr_pick(i_req_cpu, i_req_ldr, r_last);
    o_gnt_cpu = w_any & (w_pick == OWN_CPU);
    o_gnt_ldr = w_any & (w_pick == OWN_LDR);
  end

  // Last-granted flag: updates on every grant, loader after reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= RST_LAST_GNT;
    end else if (w_any) begin
      r_last <= w_pick;
    end else begin
      r_last <= r_last;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates a CPU port and a program-loader/debug port onto one single-port
// synchronous memory. One access in flight at a time: grant in IDLE, memory
// command in ISSUE, read data returned in RESP.
//   clk, rst_n                      : clock, synchronous active-low reset
//   i_cpu_req/we/addr/wdata         : CPU request (held until o_cpu_gnt)
//   o_cpu_gnt/rvalid/rdata/stall    : CPU grant pulse, read data, stall
//   i_ldr_req/we/addr/wdata         : loader request (held until o_ldr_gnt)
//   o_ldr_gnt/rvalid/rdata          : loader grant pulse and read data
//   i_ldr_lock                      : loader exclusive use (CPU ineligible)
//   o_mem_en/we/addr/wdata          : memory command
//   i_mem_rdata                     : memory read data, one cycle after read
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wdata,
  output logic          o_cpu_gnt,
  output logic          o_cpu_rvalid,
  output logic [DW-1:0] o_cpu_rdata,
  output logic          o_cpu_stall,
  input  logic          i_ldr_req,
  input  logic          i_ldr_we,
  input  logic [AW-1:0] i_ldr_addr,
  input  logic [DW-1:0] i_ldr_wdata,
  output logic          o_ldr_gnt,
  output logic          o_ldr_rvalid,
  output logic [DW-1:0] o_ldr_rdata,
  input  logic          i_ldr_lock,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata
);

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  owner_e        r_owner;
  logic          r_cmd_we;
  logic [AW-1:0] r_cmd_addr;
  logic [DW-1:0] r_cmd_wdata;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_ldr_rdata;

  logic w_cpu_elig;
  logic w_ldr_elig;
  logic w_arb_en;
  logic w_gnt_cpu;
  logic w_gnt_ldr;
  logic w_grant;
  logic w_resp_cpu;
  logic w_resp_ldr;
  logic w_cpu_rd_busy;

  // Request eligibility; grants only in IDLE and never while reset is held
  always_comb begin
    w_cpu_elig = i_cpu_req & ~i_ldr_lock;
    w_ldr_elig = i_ldr_req;
    w_arb_en   = rst_n & (r_state == ST_IDLE);
    w_grant    = w_gnt_cpu | w_gnt_ldr;
  end

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (w_arb_en),
    .i_req_cpu (w_cpu_elig),
    .i_req_ldr (w_ldr_elig),
    .o_gnt_cpu (w_gnt_cpu),
    .o_gnt_ldr (w_gnt_ldr)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and per-state strobes. Strobes are also gated by rst_n so
  // that an access caught by reset produces no enable or response.
  always_comb begin
    w_state_nxt   = r_state;
    o_mem_en      = 1'b0;
    o_mem_we      = 1'b0;
    w_resp_cpu    = 1'b0;
    w_resp_ldr    = 1'b0;
    w_cpu_rd_busy = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_state_nxt = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        o_mem_en      = rst_n;
        o_mem_we      = rst_n & r_cmd_we;
        w_cpu_rd_busy = (r_owner == OWN_CPU) & ~r_cmd_we;
        if (r_cmd_we) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_resp_cpu    = rst_n & (r_owner == OWN_CPU);
        w_resp_ldr    = rst_n & (r_owner == OWN_LDR);
        w_cpu_rd_busy = (r_owner == OWN_CPU);
        w_state_nxt   = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Command latch: owner and command captured on the grant cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner     <= OWN_CPU;
      r_cmd_we    <= 1'b0;
      r_cmd_addr  <= {AW{1'b0}};
      r_cmd_wdata <= {DW{1'b0}};
    end else if (w_gnt_ldr) begin
      r_owner     <= OWN_LDR;
      r_cmd_we    <= i_ldr_we;
      r_cmd_addr  <= i_ldr_addr;
      r_cmd_wdata <= i_ldr_wdata;
    end else if (w_gnt_cpu) begin
      r_owner     <= OWN_CPU;
      r_cmd_we    <= i_cpu_we;
      r_cmd_addr  <= i_cpu_addr;
      r_cmd_wdata <= i_cpu_wdata;
    end else begin
      r_owner     <= r_owner;
      r_cmd_we    <= r_cmd_we;
      r_cmd_addr  <= r_cmd_addr;
      r_cmd_wdata <= r_cmd_wdata;
    end
  end

  // Read-data hold registers so rdata keeps the last returned word after RESP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cpu_rdata <= {DW{1'b0}};
      r_ldr_rdata <= {DW{1'b0}};
    end else begin
      r_cpu_rdata <= w_resp_cpu ? i_mem_rdata : r_cpu_rdata;
      r_ldr_rdata <= w_resp_ldr ? i_mem_rdata : r_ldr_rdata;
    end
  end

  // Port outputs. Read data passes straight through during RESP because the
  // memory word only becomes valid in that cycle.
  always_comb begin
    o_cpu_gnt    = w_gnt_cpu;
    o_ldr_gnt    = w_gnt_ldr;
    o_cpu_rvalid = w_resp_cpu;
    o_ldr_rvalid = w_resp_ldr;
    o_cpu_rdata  = w_resp_cpu ? i_mem_rdata : r_cpu_rdata;
    o_ldr_rdata  = w_resp_ldr ? i_mem_rdata : r_ldr_rdata;
    o_cpu_stall  = (i_cpu_req & ~w_gnt_cpu) | w_cpu_rd_busy;
    o_mem_addr   = r_cmd_addr;
    o_mem_wdata  = r_cmd_wdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stall;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        ldr_req, ldr_we, ldr_gnt, ldr_rvalid, ldr_lock;
  logic [15:0] ldr_addr, ldr_wdata, ldr_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic        pre_we;
  logic [15:0] pre_addr, pre_data;
  logic [15:0] mem [0:65535];

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.AW(16), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_gnt(cpu_gnt), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
    .i_ldr_req(ldr_req), .i_ldr_we(ldr_we), .i_ldr_addr(ldr_addr), .i_ldr_wdata(ldr_wdata),
    .o_ldr_gnt(ldr_gnt), .o_ldr_rvalid(ldr_rvalid), .o_ldr_rdata(ldr_rdata),
    .i_ldr_lock(ldr_lock),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  // Synchronous single-port memory, with a bench-only preload port
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 16'h0000; ldr_wdata = 16'h0000;
    ldr_lock = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs(); rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d; tick(); pre_we = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs(); cpu_req = 1'b1; ldr_req = 1'b1; rst_n = 1'b0;
    tick(); tick(); #2;
    checks++; if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL rst_cpu_gnt got %0b want 0", cpu_gnt); end
    checks++; if (ldr_gnt !== 1'b0) begin errors++; $display("FAIL rst_ldr_gnt got %0b want 0", ldr_gnt); end
    checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_en_we got %0b%0b want 00", mem_en, mem_we); end
    checks++; if (mem_addr !== 16'h0000 || mem_wdata !== 16'h0000) begin errors++; $display("FAIL rst_mem_cmd got %h/%h want 0000/0000", mem_addr, mem_wdata); end
    checks++; if (cpu_rvalid !== 1'b0 || ldr_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %0b%0b want 00", cpu_rvalid, ldr_rvalid); end
    checks++; if (cpu_rdata !== 16'h0000 || ldr_rdata !== 16'h0000) begin errors++; $display("FAIL rst_rdata got %h/%h want 0000/0000", cpu_rdata, ldr_rdata); end
    idle_inputs(); rst_n = 1'b1; tick(); #2;
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b want 0", cpu_stall); end
    tick();
  endtask

  task automatic test_cpu_read();
    preload(16'h0010, 16'hBEEF);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; #2;
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt got %0b want 1", cpu_gnt); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rd_stall_gnt got %0b want 0", cpu_stall); end
    tick(); cpu_req = 1'b0; #2;
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL rd_issue_en_we got %0b%0b want 10", mem_en, mem_we); end
    checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL rd_issue_addr got %h want 0010", mem_addr); end
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL rd_issue_stall got %0b want 1", cpu_stall); end
    checks++; if (cpu_rvalid !== 1'b0 || cpu_gnt !== 1'b0) begin errors++; $display("FAIL rd_issue_quiet got rv=%0b gnt=%0b want 0 0", cpu_rvalid, cpu_gnt); end
    tick(); #2;
    checks++; if (cpu_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid got %0b want 1", cpu_rvalid); end
    checks++; if (cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_rdata got %h want beef", cpu_rdata); end
    checks++; if (mem_en !== 1'b0 || ldr_rvalid !== 1'b0) begin errors++; $display("FAIL rd_resp_quiet got en=%0b lrv=%0b want 0 0", mem_en, ldr_rvalid); end
    tick(); #2;
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_pulse got %0b want 0", cpu_rvalid); end
    tick();
  endtask

  task automatic test_tie();
    int c_rv, l_g, l_rv;
    logic [15:0] c_d, l_d;
    c_rv = -1; l_g = -1; l_rv = -1; c_d = 16'h0000; l_d = 16'h0000;
    do_reset();
    preload(16'h0001, 16'h5A01); preload(16'h0002, 16'h5A02);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 16'h0002; #2;
    checks++; if (cpu_gnt !== 1'b1 || ldr_gnt !== 1'b0) begin errors++; $display("FAIL tie_first got cpu=%0b ldr=%0b want 1 0", cpu_gnt, ldr_gnt); end
    tick(); cpu_req = 1'b0;
    for (int c = 1; c < 12; c++) begin
      #2;
      if (cpu_rvalid && c_rv < 0) begin c_rv = c; c_d = cpu_rdata; end
      if (ldr_gnt && l_g < 0) l_g = c;
      if (ldr_rvalid && l_rv < 0) begin l_rv = c; l_d = ldr_rdata; end
      tick();
      if (l_g >= 0) ldr_req = 1'b0;
    end
    checks++; if (c_rv != 2) begin errors++; $display("FAIL tie_cpu_rv_cycle got %0d want 2", c_rv); end
    checks++; if (l_g != 3) begin errors++; $display("FAIL tie_ldr_gnt_cycle got %0d want 3", l_g); end
    checks++; if (l_rv - c_rv != 3) begin errors++; $display("FAIL tie_rv_gap got %0d want 3", l_rv - c_rv); end
    checks++; if (c_d !== 16'h5A01 || l_d !== 16'h5A02) begin errors++; $display("FAIL tie_data got %h/%h want 5a01/5a02", c_d, l_d); end
  endtask

  task automatic test_lock();
    bit got;
    preload(16'h0040, 16'hC0DE);
    ldr_lock = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
    for (int k = 0; k < 4; k++) begin
      ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 16'(k); ldr_wdata = 16'h1111 * 16'(k + 1);
      got = 1'b0;
      for (int c = 0; c < 6 && !got; c++) begin
        #2;
        checks++; if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL lock_cpu_gnt got %0b want 0", cpu_gnt); end
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL lock_stall got %0b want 1", cpu_stall); end
        if (ldr_gnt) got = 1'b1;
        tick();
      end
      ldr_req = 1'b0;
      checks++; if (!got) begin errors++; $display("FAIL lock_wr_timeout write %0d got no gnt want gnt", k); end
    end
    #2;
    checks++; if (cpu_stall !== 1'b1 || cpu_gnt !== 1'b0) begin errors++; $display("FAIL lock_last_issue got stall=%0b gnt=%0b want 1 0", cpu_stall, cpu_gnt); end
    tick(); #2;
    checks++; if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL lock_idle_gnt got %0b want 0", cpu_gnt); end
    tick(); ldr_lock = 1'b0; #2;
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL unlock_gnt got %0b want 1", cpu_gnt); end
    tick(); cpu_req = 1'b0; tick(); #2;
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hC0DE) begin errors++; $display("FAIL unlock_read got rv=%0b d=%h want 1 c0de", cpu_rvalid, cpu_rdata); end
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++; if (mem[k] !== 16'h1111 * 16'(k + 1)) begin errors++; $display("FAIL lock_mem[%0d] got %h want %h", k, mem[k], 16'h1111 * 16'(k + 1)); end
    end
  endtask

  task automatic test_reset_mid();
    preload(16'h0050, 16'h7777);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0050; #2;
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt got %0b want 1", cpu_gnt); end
    tick(); cpu_req = 1'b0; tick(); rst_n = 1'b0; #2;
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_rvalid_in_reset got %0b want 0", cpu_rvalid); end
    tick(); rst_n = 1'b1; #2;
    checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || cpu_gnt !== 1'b0 || ldr_gnt !== 1'b0) begin errors++; $display("FAIL rmid_ctl got en=%0b we=%0b cg=%0b lg=%0b want 0", mem_en, mem_we, cpu_gnt, ldr_gnt); end
    checks++; if (mem_addr !== 16'h0000 || mem_wdata !== 16'h0000) begin errors++; $display("FAIL rmid_cmd got %h/%h want 0000/0000", mem_addr, mem_wdata); end
    checks++; if (cpu_rdata !== 16'h0000 || ldr_rdata !== 16'h0000) begin errors++; $display("FAIL rmid_rdata got %h/%h want 0000/0000", cpu_rdata, ldr_rdata); end
    checks++; if (cpu_rvalid !== 1'b0 || ldr_rvalid !== 1'b0 || cpu_stall !== 1'b0) begin errors++; $display("FAIL rmid_rv_stall got %0b%0b%0b want 000", cpu_rvalid, ldr_rvalid, cpu_stall); end
    for (int c = 0; c < 3; c++) begin
      tick(); #2;
      checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_late_rvalid got %0b want 0", cpu_rvalid); end
    end
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0050;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 16'h0050; #2;
    checks++; if (cpu_gnt !== 1'b1 || ldr_gnt !== 1'b0) begin errors++; $display("FAIL rmid_tie got cpu=%0b ldr=%0b want 1 0", cpu_gnt, ldr_gnt); end
    tick(); cpu_req = 1'b0; ldr_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++; if (ldr_gnt !== 1'b0 || ldr_rvalid !== 1'b0) begin errors++; $display("FAIL withdraw_ldr got gnt=%0b rv=%0b want 0 0", ldr_gnt, ldr_rvalid); end
      tick();
    end
  endtask

  task automatic test_wr_rd();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'h00A5; #2;
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt got %0b want 1", cpu_gnt); end
    tick(); cpu_req = 1'b0; #2;
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0020 || mem_wdata !== 16'h00A5) begin errors++; $display("FAIL wr_issue got en=%0b we=%0b a=%h d=%h want 1 1 0020 00a5", mem_en, mem_we, mem_addr, mem_wdata); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL wr_stall got %0b want 0", cpu_stall); end
    tick();
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 16'h0020; #2;
    checks++; if (ldr_gnt !== 1'b1) begin errors++; $display("FAIL wrrd_ldr_gnt got %0b want 1", ldr_gnt); end
    tick(); ldr_req = 1'b0; tick(); #2;
    checks++; if (ldr_rvalid !== 1'b1 || ldr_rdata !== 16'h00A5 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL wrrd_data got lrv=%0b d=%h crv=%0b want 1 00a5 0", ldr_rvalid, ldr_rdata, cpu_rvalid); end
    tick();
  endtask

  // Random traffic against a transaction-level model: grant order from the
  // round-robin rule, shadow memory, fixed read latency of two cycles.
  task automatic test_random();
    logic [15:0] shadow [0:15];
    int rv_cyc[$]; bit rv_ldr[$]; logic [15:0] rv_dat[$];
    bit last_ldr, cpu_done, ldr_done, c_el, l_el, win_ldr, w_we;
    bit exp_cg, exp_lg, exp_cv, exp_lv, exp_st;
    logic [15:0] exp_cd, exp_ld, w_addr, w_data;
    int busy, cpu_rd_g;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      shadow[i] = 16'($urandom);
      preload(16'h0100 + 16'(i), shadow[i]);
    end
    last_ldr = 1'b1; busy = 0; cpu_rd_g = -10; cpu_done = 1'b0; ldr_done = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cpu_done) begin cpu_req = 1'b0; cpu_done = 1'b0; end
      else if (!cpu_req) begin
        if ($urandom_range(0, 2) == 0) begin
          cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
          cpu_addr = 16'h0100 + 16'($urandom_range(0, 15)); cpu_wdata = 16'($urandom);
        end
      end else if ($urandom_range(0, 19) == 0) cpu_req = 1'b0;
      if (ldr_done) begin ldr_req = 1'b0; ldr_done = 1'b0; end
      else if (!ldr_req) begin
        if ($urandom_range(0, 2) == 0) begin
          ldr_req = 1'b1; ldr_we = 1'($urandom_range(0, 1));
          ldr_addr = 16'h0100 + 16'($urandom_range(0, 15)); ldr_wdata = 16'($urandom);
        end
      end else if ($urandom_range(0, 19) == 0) ldr_req = 1'b0;
      if ($urandom_range(0, 24) == 0) ldr_lock = !ldr_lock;
      #2;
      c_el = cpu_req && !ldr_lock; l_el = ldr_req;
      exp_cg = 1'b0; exp_lg = 1'b0;
      if (busy == 0 && (c_el || l_el)) begin
        win_ldr = (c_el && l_el) ? !last_ldr : l_el;
        last_ldr = win_ldr;
        w_we = win_ldr ? ldr_we : cpu_we;
        w_addr = win_ldr ? ldr_addr : cpu_addr;
        w_data = win_ldr ? ldr_wdata : cpu_wdata;
        if (win_ldr) begin exp_lg = 1'b1; ldr_done = 1'b1; end
        else begin exp_cg = 1'b1; cpu_done = 1'b1; end
        if (w_we) begin shadow[w_addr[3:0]] = w_data; busy = 1; end
        else begin
          rv_cyc.push_back(cyc + 2); rv_ldr.push_back(win_ldr); rv_dat.push_back(shadow[w_addr[3:0]]);
          busy = 2;
          if (!win_ldr) cpu_rd_g = cyc;
        end
      end else if (busy > 0) busy--;
      exp_cv = 1'b0; exp_lv = 1'b0; exp_cd = 16'h0000; exp_ld = 16'h0000;
      if (rv_cyc.size() > 0 && rv_cyc[0] == cyc) begin
        if (rv_ldr[0]) begin exp_lv = 1'b1; exp_ld = rv_dat[0]; end
        else begin exp_cv = 1'b1; exp_cd = rv_dat[0]; end
        void'(rv_cyc.pop_front()); void'(rv_ldr.pop_front()); void'(rv_dat.pop_front());
      end
      exp_st = (cpu_req && !exp_cg) || (cyc == cpu_rd_g + 1) || (cyc == cpu_rd_g + 2);
      checks++; if (cpu_gnt !== exp_cg || ldr_gnt !== exp_lg) begin errors++; $display("FAIL rnd_gnt cyc %0d got %0b%0b want %0b%0b", cyc, cpu_gnt, ldr_gnt, exp_cg, exp_lg); end
      checks++; if (cpu_rvalid !== exp_cv || ldr_rvalid !== exp_lv) begin errors++; $display("FAIL rnd_rvalid cyc %0d got %0b%0b want %0b%0b", cyc, cpu_rvalid, ldr_rvalid, exp_cv, exp_lv); end
      checks++; if ((exp_cv && cpu_rdata !== exp_cd) || (exp_lv && ldr_rdata !== exp_ld)) begin errors++; $display("FAIL rnd_rdata cyc %0d got %h/%h want %h/%h", cyc, cpu_rdata, ldr_rdata, exp_cd, exp_ld); end
      checks++; if (cpu_stall !== exp_st) begin errors++; $display("FAIL rnd_stall cyc %0d got %0b want %0b", cyc, cpu_stall, exp_st); end
      tick();
    end
    idle_inputs(); tick(); tick(); tick();
  endtask

  initial begin
    pre_we = 1'b0; pre_addr = 16'h0000; pre_data = 16'h0000;
    idle_inputs(); rst_n = 1'b0;
    test_reset();
    test_cpu_read();
    test_tie();
    test_lock();
    test_reset_mid();
    test_wr_rd();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: AW, 16, memory address width in bits.
REQ-002 Parameter: DW, 16, memory data width in bits.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 cpu_req / cpu_we  input  1 / 1  CPU access request and write select; held by the CPU until cpu_gnt.
REQ-006 cpu_addr / cpu_wdata  input  AW / DW  CPU address and write data.
REQ-007 cpu_gnt / cpu_rvalid  output  1 / 1  CPU request accepted (1-cycle pulse) and CPU read data valid (1-cycle pulse).
REQ-008 cpu_rdata  output  DW  CPU read data; meaningful only while cpu_rvalid=1.
REQ-009 cpu_stall  output  1  high while cpu_req=1 and the request is not yet completed; drives the controller's start/hold input.
REQ-010 ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_gnt, ldr_rvalid, ldr_rdata: the same set and widths as the cpu_* signals, for the program loader/debug port.
REQ-011 ldr_lock  input  1  while high, the loader has exclusive use of memory.
REQ-012 mem_en / mem_we  output  1 / 1  single-port synchronous memory enable and write enable.
REQ-013 mem_addr / mem_wdata  output  AW / DW  memory address and write data, registered.
REQ-014 mem_rdata  input  DW  memory read data, valid one cycle after a read with mem_en=1.

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE and RESP.
REQ-016 IDLE: if any eligible request is present, the winner's gnt SHALL pulse in that cycle, its command SHALL be latched, the owner SHALL be recorded, and the next state SHALL be ISSUE.
REQ-017 ISSUE: mem_en=1, and mem_we/mem_addr/mem_wdata SHALL equal the latched command. Next state: RESP for a read, IDLE for a write.
REQ-018 RESP: the owner's rvalid SHALL be 1 and its rdata SHALL equal mem_rdata. Next state: IDLE.
REQ-019 Read latency: rvalid SHALL be asserted 2 cycles after the gnt cycle. Write completion: the memory write SHALL occur 1 cycle after gnt.
REQ-020 No new grant SHALL be issued outside IDLE; at most one access SHALL be in flight.
REQ-021 Simultaneous eligible requests SHALL be resolved round-robin: the requester not granted last SHALL win, and the last-granted flag SHALL update on every grant.
REQ-022 A single eligible requester SHALL win regardless of the round-robin flag.
REQ-023 When ldr_lock=1, the CPU SHALL be ineligible; a CPU access already in ISSUE/RESP SHALL complete normally.
REQ-024 cpu_stall SHALL equal cpu_req AND NOT cpu_gnt, OR the CPU owning an uncompleted read in ISSUE/RESP.
REQ-025 Worst-case wait for an unlocked requester SHALL be one other access (maximum 3 cycles) before its gnt.
REQ-026 In every state other than those listed, mem_en, gnt and rvalid SHALL be 0; rdata outputs MAY hold their last value.
REQ-027 A request that is deasserted before its gnt SHALL be treated as withdrawn, with no side effect.

Reset
REQ-028 In any cycle with rst_n=0, on the clock edge: state SHALL go to IDLE; mem_en, mem_we, cpu_gnt, ldr_gnt, cpu_rvalid and ldr_rvalid SHALL go to 0; mem_addr, mem_wdata, cpu_rdata and ldr_rdata SHALL go to 0; the last-granted flag SHALL be set to loader, so the CPU wins the first tie.
REQ-029 Reset asserted mid-access SHALL abort that access; no rvalid SHALL be produced for it afterwards.

Structure
REQ-030 The state encoding (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2) and the owner encoding (CPU=0, LDR=1) SHALL reside in the shared CPU package beside the controller state constants.
REQ-031 The grant decision SHALL be one sub-module, rr_arb2 (2-input round-robin, combinational pick plus registered last-granted flag); the FSM and data muxing SHALL stay in mem_arbiter.

Verification
REQ-032 CPU-only read: cpu_req=1, we=0, addr=0x0010, memory[0x0010]=0xBEEF -> cpu_gnt at T, mem_en at T+1, cpu_rvalid=1 and cpu_rdata=0xBEEF at T+2.
REQ-033 Tie after reset: both request reads, addresses 0x0001 and 0x0002 -> CPU granted first; loader granted on the next IDLE; loader rvalid 3 cycles after cpu_rvalid.
REQ-034 Lock: ldr_lock=1 with 4 loader writes to 0x0000..0x0003 (data 0x1111..0x4444) while cpu_req=1 -> cpu_stall=1 throughout and no cpu_gnt; memory contents correct; CPU granted at the first IDLE after lock drops.
REQ-035 Reset mid-read: rst_n=0 during RESP of a CPU read -> no cpu_rvalid; all outputs 0 on the next cycle; CPU wins the next tie.
REQ-036 Write/read ordering: CPU write 0x00A5 to 0x0020, then loader read of 0x0020 -> ldr_rdata=0x00A5.
